gpg3_set_cmd_sched: RTL

- Parametrised scheduler for GoPiGo3 SET commands (motor DPS, LED RGB, servo pulse, DPS limit, ...), generalised to G_NCH channels of configurable width.
- Detects value changes per channel, arbitrates round-robin, and serialises each command as an SPI frame byte stream (address, message type, payload MSB-first) to the SPI byte engine.
- Adds a periodic refresh that resends all enabled channels, and resends every enabled channel after reset.

---
 rtl/gpg3_set_cmd_sched_if.sv | 21 ++
 rtl/gpg3_set_cmd_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpg3_set_cmd_sched_if.sv
// Byte-stream handshake between the SET command scheduler and the SPI byte engine.
interface gpg3_set_cmd_sched_if;
  logic [7:0] tx_byte_o;
  logic       tx_vld_o;
  logic       tx_rdy_i;
  logic       tx_last_o;

  modport master (
    output tx_byte_o,
    output tx_vld_o,
    output tx_last_o,
    input  tx_rdy_i
  );

  modport slave (
    input  tx_byte_o,
    input  tx_vld_o,
    input  tx_last_o,
    output tx_rdy_i
  );
endinterface

// File: rtl/gpg3_set_cmd_sched.sv
// GoPiGo3 SET command scheduler: per-channel change detection, round-robin
// arbitration, periodic refresh and serialisation of each command into an
// SPI frame (address, message type, payload MSB-first).
module gpg3_set_cmd_sched #(
  parameter int         G_CLK_FREQ_MHZ = 12,
  parameter int         G_NCH          = 4,
  parameter int         G_DW           = 32,
  parameter int         G_REFRESH_MS   = 100,
  parameter logic [7:0] G_SPI_ADDR     = 8'h08
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [G_NCH-1:0]        ch_en_i,
  input  logic [G_NCH*G_DW-1:0]   ch_val_i,
  input  logic [G_NCH*8-1:0]      ch_type_i,
  input  logic [G_NCH*3-1:0]      ch_nbytes_i,
  gpg3_set_cmd_sched_if.master    tx,
  output logic [G_NCH-1:0]        pend_o,
  output logic [G_NCH-1:0]        sent_o,
  output logic                    busy_o
);

  localparam int          RW         = (G_NCH > 1) ? $clog2(G_NCH) : 1;
  localparam int          NB_MAX     = G_DW / 8;
  localparam int          REF_PERIOD = G_CLK_FREQ_MHZ * 1000 * G_REFRESH_MS;
  localparam logic [31:0] REF_LAST   = (REF_PERIOD > 0) ? 32'(REF_PERIOD - 1) : 32'd0;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_TYPE = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Payload byte count: 0 means one byte, anything beyond the channel width is clamped.
  function automatic logic [2:0] clamp_nbytes(input logic [2:0] nb);
    if (nb == 3'd0)
      return 3'd1;
    if (int'(nb) > NB_MAX)
      return 3'(NB_MAX);
    return nb;
  endfunction

  logic [2:0]            state_q, state_d;
  logic [RW-1:0]         rr_q, rr_d;
  logic [RW-1:0]         sel_q, sel_d;
  logic [G_NCH-1:0]      pend_q, pend_d;
  logic [G_NCH*G_DW-1:0] snap_q, snap_d;
  logic                  init_q, init_d;
  logic [31:0]           ref_cnt_q, ref_cnt_d;
  logic [G_DW-1:0]       val_sh_q, val_sh_d;
  logic [7:0]            type_sh_q, type_sh_d;
  logic [2:0]            bcnt_q, bcnt_d;

  logic                  ref_tick;
  logic                  any_pend;
  logic [RW-1:0]         rr_sel;
  logic                  load_en;
  logic [7:0]            data_byte;

  // Refresh counter: one-cycle tick at the end of every refresh period.
  always_comb begin
    ref_tick  = 1'b0;
    ref_cnt_d = 32'd0;
    if (REF_PERIOD > 0) begin
      if (ref_cnt_q == REF_LAST) begin
        ref_tick  = 1'b1;
        ref_cnt_d = 32'd0;
      end else begin
        ref_cnt_d = ref_cnt_q + 32'd1;
      end
    end
  end

  // Round-robin pick: lowest pending index at or above rr, wrapping around.
  always_comb begin
    int idx;
    idx      = 0;
    any_pend = 1'b0;
    rr_sel   = '0;
    for (int i = 0; i < G_NCH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= G_NCH)
        idx = idx - G_NCH;
      if (!any_pend && pend_q[idx]) begin
        any_pend = 1'b1;
        rr_sel   = RW'(idx);
      end
    end
  end

  // Frame sequencer: LOAD latches the winner, then ADDR/TYPE/DATA advance on rdy.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    sel_d     = sel_q;
    val_sh_d  = val_sh_q;
    type_sh_d = type_sh_q;
    bcnt_d    = bcnt_q;
    load_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|pend_q)
          state_d = S_LOAD;
      end
      S_LOAD: begin
        // A channel disabled between IDLE and LOAD can leave nothing to send.
        if (any_pend) begin
          load_en   = 1'b1;
          sel_d     = rr_sel;
          val_sh_d  = ch_val_i[int'(rr_sel)*G_DW +: G_DW];
          type_sh_d = ch_type_i[int'(rr_sel)*8 +: 8];
          bcnt_d    = clamp_nbytes(ch_nbytes_i[int'(rr_sel)*3 +: 3]) - 3'd1;
          rr_d      = (int'(rr_sel) == G_NCH - 1) ? '0 : rr_sel + 1'b1;
          state_d   = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (tx.tx_rdy_i)
          state_d = S_TYPE;
      end
      S_TYPE: begin
        if (tx.tx_rdy_i)
          state_d = S_DATA;
      end
      S_DATA: begin
        if (tx.tx_rdy_i) begin
          if (bcnt_q == 3'd0)
            state_d = S_DONE;
          else
            bcnt_d = bcnt_q - 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Snapshot of the last value handed to the frame engine, per channel.
  always_comb begin
    snap_d = snap_q;
    if (load_en)
      snap_d[int'(rr_sel)*G_DW +: G_DW] = ch_val_i[int'(rr_sel)*G_DW +: G_DW];
  end

  // Pending flags. The compare uses the post-LOAD snapshot so the channel being
  // loaded only re-pends if its input already differs from what was latched.
  always_comb begin
    init_d = 1'b0;
    pend_d = pend_q;
    for (int c = 0; c < G_NCH; c++) begin
      if (ch_en_i[c] &&
          ((ch_val_i[c*G_DW +: G_DW] != snap_d[c*G_DW +: G_DW]) || init_q || ref_tick))
        pend_d[c] = 1'b1;
      else if (!ch_en_i[c])
        pend_d[c] = 1'b0;
      else if (load_en && (int'(rr_sel) == c))
        pend_d[c] = 1'b0;
    end
  end

  // Payload byte selected by the down-counting byte index.
  always_comb begin
    data_byte = 8'h00;
    for (int k = 0; k < NB_MAX; k++) begin
      if (bcnt_q == 3'(k))
        data_byte = val_sh_q[k*8 +: 8];
    end
  end

  // Outputs decoded from state; held registers keep them stable while stalled.
  always_comb begin
    tx.tx_byte_o = 8'h00;
    tx.tx_vld_o  = 1'b0;
    tx.tx_last_o = 1'b0;
    sent_o       = '0;
    busy_o       = 1'b0;
    case (state_q)
      S_LOAD: begin
        busy_o = 1'b1;
      end
      S_ADDR: begin
        tx.tx_byte_o = G_SPI_ADDR;
        tx.tx_vld_o  = 1'b1;
        busy_o       = 1'b1;
      end
      S_TYPE: begin
        tx.tx_byte_o = type_sh_q;
        tx.tx_vld_o  = 1'b1;
        busy_o       = 1'b1;
      end
      S_DATA: begin
        tx.tx_byte_o = data_byte;
        tx.tx_vld_o  = 1'b1;
        tx.tx_last_o = (bcnt_q == 3'd0);
        busy_o       = 1'b1;
      end
      S_DONE: begin
        sent_o[sel_q] = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  assign pend_o = pend_q;

  // Control state with synchronous active-low reset; init flag armed by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      sel_q     <= '0;
      pend_q    <= '0;
      snap_q    <= '0;
      init_q    <= 1'b1;
      ref_cnt_q <= 32'd0;
      bcnt_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      sel_q     <= sel_d;
      pend_q    <= pend_d;
      snap_q    <= snap_d;
      init_q    <= init_d;
      ref_cnt_q <= ref_cnt_d;
      bcnt_q    <= bcnt_d;
    end
  end

  // Shadow copy of the frame being sent; only meaningful after LOAD.
  always_ff @(posedge clk) begin
    val_sh_q  <= val_sh_d;
    type_sh_q <= type_sh_d;
  end

endmodule
